updown_sweep_ctrl: RTL and testbench

Sequencer for the 5-bit up/down counter datapath: drives a programmable sweep between a low and a high bound, either once up, once down, or bouncing continuously. Wraps the counter core with a start/stop/pause control FSM, bound latching and a completion pulse. Sits between the system control logic and anything consuming `count`.

---
 rtl/updown_sweep_ctrl_pkg.sv | 36 +++
 rtl/updown_sweep_ctrl_if.sv | 46 ++++
 rtl/updown_count_core.sv | 37 +++
 rtl/updown_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/updown_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sweep_ctrl_pkg
//   Shared types and constants for the up/down sweep controller:
//   FSM state encoding, sweep mode encodings, reversal counter width and a
//   helper that folds the unused mode code onto UP_ONCE.
//   Optional feature macro: SWEEP_REVERSAL_COUNT_EN (see updown_sweep_ctrl).
// ---------------------------------------------------------------------------
package sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN_UP   = 3'd2,
    ST_RUN_DOWN = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_UP_ONCE   = 2'd0,
    MODE_DOWN_ONCE = 2'd1,
    MODE_BOUNCE    = 2'd2
  } mode_e;

  localparam int REV_W = 8;
  localparam logic [REV_W-1:0] REV_MAX = {REV_W{1'b1}};

  // Mode code 3 has no sweep of its own and behaves as UP_ONCE.
  function automatic mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_DOWN_ONCE;
      2'd2:    return MODE_BOUNCE;
      default: return MODE_UP_ONCE;
    endcase
  endfunction

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl_if
//   Control/status bundle between the system control logic (master) and the
//   sweep controller (slave).
//   master -> slave : start, stop, pause, mode[1:0], lo_bound, hi_bound
//   slave -> master : count, dir_up, busy, done, cfg_err
//                     reversals[7:0] only when SWEEP_REVERSAL_COUNT_EN is defined
// ---------------------------------------------------------------------------
interface updown_sweep_ctrl_if
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
);

  logic             start;
  logic             stop;
  logic             pause;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo_bound;
  logic [WIDTH-1:0] hi_bound;
  logic [WIDTH-1:0] count;
  logic             dir_up;
  logic             busy;
  logic             done;
  logic             cfg_err;
`ifdef SWEEP_REVERSAL_COUNT_EN
  logic [REV_W-1:0] reversals;
`endif

  modport master (
    output start, stop, pause, mode, lo_bound, hi_bound,
`ifdef SWEEP_REVERSAL_COUNT_EN
    input  reversals,
`endif
    input  count, dir_up, busy, done, cfg_err
  );

  modport slave (
    input  start, stop, pause, mode, lo_bound, hi_bound,
`ifdef SWEEP_REVERSAL_COUNT_EN
    output reversals,
`endif
    output count, dir_up, busy, done, cfg_err
  );

endinterface

// File: rtl/updown_count_core.sv
// ---------------------------------------------------------------------------
// updown_count_core
//   Plain WIDTH-bit up/down counter register. No bound logic: the caller
//   decides when to load, step and in which direction.
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high, clears count to 0
//   load     in   count <= load_val (has priority over en)
//   load_val in   value loaded on load
//   en       in   step by one this cycle
//   up       in   1 = increment, 0 = decrement
//   count    out  current value
// ---------------------------------------------------------------------------
module updown_count_core #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl
//   Sweeps a 5-bit counter between latched low/high bounds: once up, once
//   down, or bouncing continuously. Start/stop/pause control FSM around an
//   updown_count_core instance.
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high
//   bus    slave modport of updown_sweep_ctrl_if:
//          start/stop/pause/mode/lo_bound/hi_bound in,
//          count/dir_up/busy/done/cfg_err out
//   Optional feature macro: SWEEP_REVERSAL_COUNT_EN adds bus.reversals, a
//   saturating count of RUN_UP<->RUN_DOWN turnarounds since the last start.
//   Priority each cycle: reset > stop > pause > normal transitions.
// ---------------------------------------------------------------------------
module updown_sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_sweep_ctrl_if.slave   bus
);

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             dir_up_q, dir_up_d;
  logic             cfg_err_q, cfg_err_d;

  logic             core_load, core_en, core_up;
  logic [WIDTH-1:0] core_load_val;
  logic [WIDTH-1:0] count;

  logic idle_like, start_req, start_ok, start_bad;
  logic at_hi, at_lo, span;

  // start is only considered in IDLE/DONE, and a simultaneous stop kills it.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_req = idle_like && bus.start && !bus.stop;
  assign start_bad = start_req && (bus.lo_bound > bus.hi_bound);
  assign start_ok  = start_req && !start_bad;

  assign at_hi = (count == hi_q);
  assign at_lo = (count == lo_q);
  // Latched bounds always satisfy lo <= hi, so lo != hi means lo < hi.
  assign span  = (lo_q != hi_q);

  // State register plus latched sweep configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_UP_ONCE;
      lo_q      <= '0;
      hi_q      <= '0;
      dir_up_q  <= 1'b1;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_up_q  <= dir_up_d;
      cfg_err_q <= cfg_err_d;
      if (start_ok) begin
        lo_q   <= bus.lo_bound;
        hi_q   <= bus.hi_bound;
        mode_q <= norm_mode(bus.mode);
      end
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: state_d = start_ok ? ST_LOAD : ST_IDLE;
        ST_LOAD:          state_d = (mode_q == MODE_DOWN_ONCE) ? ST_RUN_DOWN : ST_RUN_UP;
        ST_RUN_UP: begin
          if (!bus.pause && at_hi) begin
            if (mode_q != MODE_BOUNCE) state_d = ST_DONE;
            else if (span)             state_d = ST_RUN_DOWN;
          end
        end
        ST_RUN_DOWN: begin
          if (!bus.pause && at_lo) begin
            if (mode_q != MODE_BOUNCE) state_d = ST_DONE;
            else if (span)             state_d = ST_RUN_UP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath controls and next values of registered outputs. A turnaround
  // steps away from the bound in the same cycle, so bouncing costs no extra
  // cycle at either end. A degenerate bounce (lo == hi) just holds.
  always_comb begin
    core_load     = 1'b0;
    core_load_val = lo_q;
    core_en       = 1'b0;
    core_up       = dir_up_q;
    dir_up_d      = dir_up_q;
    cfg_err_d     = start_bad;
    if (!bus.stop) begin
      case (state_q)
        ST_LOAD: begin
          core_load = 1'b1;
          if (mode_q == MODE_DOWN_ONCE) begin
            core_load_val = hi_q;
            dir_up_d      = 1'b0;
          end else begin
            dir_up_d      = 1'b1;
          end
        end
        ST_RUN_UP: begin
          if (!bus.pause) begin
            if (!at_hi) begin
              core_en = 1'b1;
              core_up = 1'b1;
            end else if (mode_q == MODE_BOUNCE && span) begin
              core_en  = 1'b1;
              core_up  = 1'b0;
              dir_up_d = 1'b0;
            end
          end
        end
        ST_RUN_DOWN: begin
          if (!bus.pause) begin
            if (!at_lo) begin
              core_en = 1'b1;
              core_up = 1'b0;
            end else if (mode_q == MODE_BOUNCE && span) begin
              core_en  = 1'b1;
              core_up  = 1'b1;
              dir_up_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  updown_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .up       (core_up),
    .count    (count)
  );

  assign bus.count   = count;
  assign bus.dir_up  = dir_up_q;
  assign bus.busy    = (state_q == ST_LOAD) || (state_q == ST_RUN_UP) ||
                       (state_q == ST_RUN_DOWN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.cfg_err = cfg_err_q;

`ifdef SWEEP_REVERSAL_COUNT_EN
  logic [REV_W-1:0] rev_q;
  logic             rev_inc;

  assign rev_inc = ((state_q == ST_RUN_UP)   && (state_d == ST_RUN_DOWN)) ||
                   ((state_q == ST_RUN_DOWN) && (state_d == ST_RUN_UP));

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      rev_q <= '0;
    end else if (rev_inc && (rev_q != REV_MAX)) begin
      rev_q <= rev_q + 1'b1;
    end
  end

  assign bus.reversals = rev_q;
`endif

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_sweep_ctrl
//   Directed table-driven bench for updown_sweep_ctrl, plus hand-written
//   sequences for bounce, reset mid-sweep and the degenerate lo == hi bounce.
//   Reversal checks are compiled in when SWEEP_REVERSAL_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

  localparam int WIDTH = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  updown_sweep_ctrl_if #(.WIDTH(WIDTH)) bus ();

  updown_sweep_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa,
                       input logic [1:0] m, input logic [4:0] lo, input logic [4:0] hi);
    bus.start    = st;
    bus.stop     = sp;
    bus.pause    = pa;
    bus.mode     = m;
    bus.lo_bound = lo;
    bus.hi_bound = hi;
  endtask

  typedef struct {
    logic       st, sp, pa;
    logic [1:0] mode;
    logic [4:0] lo, hi;
    logic [4:0] cnt;
    logic       dir, busy, done, cfg;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sp, input logic pa,
                              input logic [1:0] m, input logic [4:0] lo, input logic [4:0] hi,
                              input logic [4:0] cnt, input logic dir, input logic busy,
                              input logic done, input logic cfg);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.mode = m; v.lo = lo; v.hi = hi;
    v.cnt = cnt; v.dir = dir; v.busy = busy; v.done = done; v.cfg = cfg;
    return v;
  endfunction

  localparam int NV = 35;
  vec_t vecs[NV];

  int bexp[12] = '{2, 3, 4, 3, 2, 3, 4, 3, 2, 3, 4, 3};

  initial begin
    // Inputs applied before an edge; expectations are the outputs after it.
    //              st sp pa mode lo  hi    cnt dir busy done cfg
    // UP_ONCE 0..3
    vecs[0]  = mk(1, 0, 0, 2'd0, 0,  3,    0, 1, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 2'd0, 0,  3,    0, 1, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 2'd0, 0,  3,    1, 1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 2'd0, 0,  3,    2, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 2'd0, 0,  3,    3, 1, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 2'd0, 0,  3,    3, 1, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 2'd0, 0,  3,    3, 1, 0, 0, 0);
    // rejected start lo > hi
    vecs[7]  = mk(1, 0, 0, 2'd0, 10, 4,    3, 1, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 2'd0, 10, 4,    3, 1, 0, 0, 0);
    // DOWN_ONCE 9..5, pause at 7, start while busy ignored
    vecs[9]  = mk(1, 0, 0, 2'd1, 5,  9,    3, 1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 2'd1, 5,  9,    9, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 2'd1, 5,  9,    8, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 2'd1, 5,  9,    7, 0, 1, 0, 0);
    vecs[13] = mk(0, 0, 1, 2'd1, 5,  9,    7, 0, 1, 0, 0);
    vecs[14] = mk(0, 0, 1, 2'd1, 5,  9,    7, 0, 1, 0, 0);
    vecs[15] = mk(0, 0, 1, 2'd1, 5,  9,    7, 0, 1, 0, 0);
    vecs[16] = mk(1, 0, 0, 2'd0, 10, 4,    6, 0, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 2'd1, 5,  9,    5, 0, 1, 0, 0);
    vecs[18] = mk(0, 0, 0, 2'd1, 5,  9,    5, 0, 0, 1, 0);
    vecs[19] = mk(0, 0, 0, 2'd1, 5,  9,    5, 0, 0, 0, 0);
    // mode 3 acts as UP_ONCE; stop+start at count 6 aborts with no done
    vecs[20] = mk(1, 0, 0, 2'd3, 4,  9,    5, 0, 1, 0, 0);
    vecs[21] = mk(0, 0, 0, 2'd3, 4,  9,    4, 1, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 2'd3, 4,  9,    5, 1, 1, 0, 0);
    vecs[23] = mk(0, 0, 0, 2'd3, 4,  9,    6, 1, 1, 0, 0);
    vecs[24] = mk(1, 1, 0, 2'd0, 0,  3,    6, 1, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 2'd0, 0,  3,    6, 1, 0, 0, 0);
    // UP_ONCE 1..2, restart from DONE into DOWN_ONCE 1..0, pause ignored in LOAD
    vecs[26] = mk(1, 0, 0, 2'd0, 1,  2,    6, 1, 1, 0, 0);
    vecs[27] = mk(0, 0, 0, 2'd0, 1,  2,    1, 1, 1, 0, 0);
    vecs[28] = mk(0, 0, 0, 2'd0, 1,  2,    2, 1, 1, 0, 0);
    vecs[29] = mk(0, 0, 0, 2'd0, 1,  2,    2, 1, 0, 1, 0);
    vecs[30] = mk(1, 0, 0, 2'd1, 0,  1,    2, 1, 1, 0, 0);
    vecs[31] = mk(0, 0, 1, 2'd1, 0,  1,    1, 0, 1, 0, 0);
    vecs[32] = mk(0, 0, 0, 2'd1, 0,  1,    0, 0, 1, 0, 0);
    vecs[33] = mk(0, 0, 0, 2'd1, 0,  1,    0, 0, 0, 1, 0);
    vecs[34] = mk(0, 1, 0, 2'd1, 0,  1,    0, 0, 0, 0, 0);

    drive(0, 0, 0, 2'd0, 0, 0);
    reset = 1'b1;
    step();
    step();
    check("reset count",   32'(bus.count),   0);
    check("reset dir_up",  32'(bus.dir_up),  1);
    check("reset busy",    32'(bus.busy),    0);
    check("reset done",    32'(bus.done),    0);
    check("reset cfg_err", 32'(bus.cfg_err), 0);
`ifdef SWEEP_REVERSAL_COUNT_EN
    check("reset reversals", 32'(bus.reversals), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].mode, vecs[i].lo, vecs[i].hi);
      step();
      check($sformatf("v%0d count", i),   32'(bus.count),   32'(vecs[i].cnt));
      check($sformatf("v%0d dir_up", i),  32'(bus.dir_up),  32'(vecs[i].dir));
      check($sformatf("v%0d busy", i),    32'(bus.busy),    32'(vecs[i].busy));
      check($sformatf("v%0d done", i),    32'(bus.done),    32'(vecs[i].done));
      check($sformatf("v%0d cfg_err", i), 32'(bus.cfg_err), 32'(vecs[i].cfg));
    end

    // BOUNCE 2..4 for 12 steps, then reset while count is 3.
    drive(1, 0, 0, 2'd2, 2, 4);
    step();
    check("bounce busy", 32'(bus.busy), 1);
    drive(0, 0, 0, 2'd2, 2, 4);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("bounce count[%0d]", i), 32'(bus.count), 32'(bexp[i]));
      check($sformatf("bounce busy[%0d]", i),  32'(bus.busy),  1);
      check($sformatf("bounce done[%0d]", i),  32'(bus.done),  0);
`ifdef SWEEP_REVERSAL_COUNT_EN
      if (i == 9) check("bounce reversals", 32'(bus.reversals), 4);
`endif
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset count",  32'(bus.count),  0);
    check("midreset busy",   32'(bus.busy),   0);
    check("midreset dir_up", 32'(bus.dir_up), 1);
    check("midreset done",   32'(bus.done),   0);
`ifdef SWEEP_REVERSAL_COUNT_EN
    check("midreset reversals", 32'(bus.reversals), 0);
`endif
    step();
    check("midreset idle busy",  32'(bus.busy),  0);
    check("midreset idle count", 32'(bus.count), 0);

    // Degenerate bounce lo == hi == 7: holds at 7, never turns around.
    drive(1, 0, 0, 2'd2, 7, 7);
    step();
    drive(0, 0, 0, 2'd2, 7, 7);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("flat count[%0d]", i), 32'(bus.count), 7);
      check($sformatf("flat busy[%0d]", i),  32'(bus.busy),  1);
    end
`ifdef SWEEP_REVERSAL_COUNT_EN
    check("flat reversals", 32'(bus.reversals), 0);
`endif
    drive(0, 1, 0, 2'd2, 7, 7);
    step();
    check("flat stop busy",  32'(bus.busy),  0);
    check("flat stop count", 32'(bus.count), 7);
    check("flat stop done",  32'(bus.done),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
